// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer: shifter state encoding and counter sizing.
package serdes_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Bit-counter width for a given word width (always at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register that parks the next word while the shifter is busy.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one registered bit per clock out.
module bit_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             BUSY
);

    localparam int CW = cnt_width(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_load, hold_drain;
    logic             accept, last_bit, load_new, load_word;
    logic [WIDTH-1:0] load_value, sh_rot;
    logic             load_first_bit, next_bit;

    assign IN_READY   = !hold_full && !RST;
    assign accept     = IN_VALID && IN_READY;
    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign hold_drain = last_bit && hold_full;
    assign load_new   = accept && ((state_q == ST_IDLE) || (last_bit && !hold_full));
    assign hold_load  = accept && !load_new;
    assign load_word  = hold_drain || load_new;
    assign load_value = hold_drain ? hold_data : IN_DATA;

    // Rotating rather than shifting keeps every bit of sh in use; the vacated bit is never sent.
    generate
        if (MSB_FIRST) begin : g_msb
            assign load_first_bit = load_value[WIDTH-1];
            assign next_bit       = sh_q[WIDTH-2];
            assign sh_rot         = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
        end else begin : g_lsb
            assign load_first_bit = load_value[0];
            assign next_bit       = sh_q[1];
            assign sh_rot         = {sh_q[0], sh_q[WIDTH-1:1]};
        end
    endgenerate

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .CLK     (CLK),
        .RST     (RST),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .data_i  (IN_DATA),
        .data_o  (hold_data),
        .full_o  (hold_full)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit && !load_word) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A load always restarts the word, so it takes priority over a normal shift.
    always_comb begin
        sh_d        = sh_q;
        cnt_d       = '0;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        if (load_word) begin
            sh_d        = load_value;
            ser_out_d   = load_first_bit;
            ser_valid_d = 1'b1;
        end else if ((state_q == ST_SHIFT) && !last_bit) begin
            sh_d        = sh_rot;
            cnt_d       = cnt_q + CW'(1);
            ser_out_d   = next_bit;
            ser_valid_d = 1'b1;
        end
    end

    assign SER_OUT   = ser_out_q;
    assign SER_VALID = ser_valid_q;
    assign BUSY      = (state_q == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1) against a bit-queue model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] IN_DATA;
    logic         IN_VALID;
    logic         ready_a, ser_a, sv_a, busy_a;
    logic         ready_b, ser_b, sv_b, busy_b;

    bit qa[$];
    bit qb[$];
    int tests;
    int fails;
    logic acc_last;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(ready_a), .SER_OUT(ser_a), .SER_VALID(sv_a), .BUSY(busy_a)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(ready_b), .SER_OUT(ser_b), .SER_VALID(sv_b), .BUSY(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // qa[0] is the bit on the line this cycle; more than one word queued means the hold slot is full.
    function automatic logic exp_ready();
        return !RST && (qa.size() <= W);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("ready_a", {31'd0, ready_a}, {31'd0, exp_ready()});
        check("ready_b", {31'd0, ready_b}, {31'd0, exp_ready()});
        check("ser_valid_a", {31'd0, sv_a}, (qa.size() != 0) ? 32'd1 : 32'd0);
        check("ser_out_a", {31'd0, ser_a}, (qa.size() != 0) ? {31'd0, qa[0]} : 32'd0);
        check("busy_a", {31'd0, busy_a}, (qa.size() != 0) ? 32'd1 : 32'd0);
        check("ser_valid_b", {31'd0, sv_b}, (qb.size() != 0) ? 32'd1 : 32'd0);
        check("ser_out_b", {31'd0, ser_b}, (qb.size() != 0) ? {31'd0, qb[0]} : 32'd1);
        check("busy_b", {31'd0, busy_b}, (qb.size() != 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(input logic v, input logic [W-1:0] d);
        bit tmp;
        IN_VALID = v;
        IN_DATA  = d;
        acc_last = v && exp_ready();
        @(posedge CLK);
        if (qa.size() != 0) begin
            tmp = qa.pop_front();
            tmp = qb.pop_front();
        end
        if (RST) begin
            qa.delete();
            qb.delete();
        end else if (acc_last) begin
            for (int i = W - 1; i >= 0; i--) qa.push_back(d[i]);
            for (int i = 0; i < W; i++) qb.push_back(d[i]);
            $display("[TB] t=%0t accept word %h", $time, d);
        end
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        logic [W-1:0] words [3];
        int idx, guard, run, best;

        tests    = 0;
        fails    = 0;
        acc_last = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        RST      = 1'b1;

        // Reset state, including IN_READY held low during reset.
        repeat (3) begin
            @(negedge CLK);
            check_all();
        end
        RST = 1'b0;
        #1;
        check_all();
        check("ready_after_release", {31'd0, ready_a}, 32'd1);

        // Idle line levels.
        repeat (4) tick(1'b0, 8'h00);

        // Single word 8'hB3.
        tick(1'b1, 8'hB3);
        repeat (10) tick(1'b0, 8'h00);

        // Streaming three words with IN_VALID held high.
        words[0] = 8'h4C;
        words[1] = 8'hFF;
        words[2] = 8'h00;
        idx = 0; guard = 0; run = 0; best = 0;
        while (idx < 3 && guard < 60) begin
            tick(1'b1, words[idx]);
            if (acc_last) idx++;
            guard++;
            run  = sv_a ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        check("stream_words_accepted", idx, 3);
        repeat (30) begin
            tick(1'b0, 8'h00);
            run  = sv_a ? run + 1 : 0;
            best = (run > best) ? run : best;
        end
        check("stream_gapless_run", best, 24);

        // Bypass exactly on the last-bit edge with hold empty.
        tick(1'b1, 8'hA5);
        repeat (7) tick(1'b0, 8'h00);
        check("bypass_ready", {31'd0, ready_a}, 32'd1);
        tick(1'b1, 8'h5A);
        check("bypass_accepted", {31'd0, acc_last}, 32'd1);
        repeat (12) tick(1'b0, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 3) != 0), W'($urandom));
        end
        repeat (20) tick(1'b0, 8'h00);

        // Reset mid-word with a second word held.
        tick(1'b1, 8'hB3);
        tick(1'b1, 8'h96);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        #2;
        RST = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        check_all();
        check("mid_rst_sv", {31'd0, sv_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        RST = 1'b0;
        #1;
        check_all();
        repeat (20) tick(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
